// File: rtl/line_ctrl_pkg.sv
// Shared types and helpers for the line-following steering core.
package line_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SEARCH = 2'd2,
        ST_STOP   = 2'd3
    } ctrl_state_t;

    // Working width of sat_speed; callers keep SPEED_W + 2 within it.
    localparam int SAT_W = 32;

    // Odd, symmetric sensor weight: -(n-1) .. +(n-1).
    function automatic int weight(input int i, input int n);
        return 2 * i - (n - 1);
    endfunction

    // Clamp a signed value into [0, 2^speed_w - 1].
    function automatic logic [SAT_W-1:0] sat_speed(input logic signed [SAT_W-1:0] v,
                                                   input int speed_w);
        logic signed [SAT_W-1:0] hi;
        hi = $signed((32'd1 << speed_w) - 32'd1);
        if (v < 0)
            return '0;
        if (v > hi)
            return $unsigned(hi);
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/line_position_estimator.sv
// Registers the raw sample, then produces the weighted line error and popcount.
module line_position_estimator
    import line_ctrl_pkg::*;
#(
    parameter int NUM_SENSORS = 8,
    parameter int ERR_W       = $clog2(NUM_SENSORS * NUM_SENSORS) + 1,
    parameter int CNT_W       = $clog2(NUM_SENSORS + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_SENSORS-1:0] sample,
    output logic [ERR_W-1:0]       err,
    output logic [CNT_W-1:0]       cnt
);

    logic [NUM_SENSORS-1:0] sample_r;
    int                     err_acc;
    int                     cnt_acc;

    always_comb begin
        err_acc = 0;
        cnt_acc = 0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (sample_r[i]) begin
                err_acc += weight(i, NUM_SENSORS);
                cnt_acc += 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_r <= '0;
            err      <= '0;
            cnt      <= '0;
        end else begin
            sample_r <= sample;
            err      <= ERR_W'(err_acc);
            cnt      <= CNT_W'(cnt_acc);
        end
    end

endmodule

// File: rtl/line_steering_controller.sv
// Line-following steering core: position estimate, PD correction, supervisory FSM
// and differential motor outputs, three cycles from sample to output.
module line_steering_controller
    import line_ctrl_pkg::*;
#(
    parameter int NUM_SENSORS  = 8,
    parameter int SPEED_W      = 21,
    parameter int KSHIFT       = 0,
    parameter int LOST_SAMPLES = 3,
    parameter int STOP_SAMPLES = 2,
    parameter int SEARCH_SPEED = 500
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               sample_valid,
    input  logic [NUM_SENSORS-1:0] sample,
    input  logic [SPEED_W-1:0] base_speed,
    input  logic [7:0]         kp,
    input  logic [7:0]         kd,
    output logic [SPEED_W-1:0] left_speed,
    output logic [SPEED_W-1:0] right_speed,
    output logic               left_dir,
    output logic               right_dir,
    output logic               update_valid,
    output logic [1:0]         ctrl_state,
    output logic               line_lost
);

    localparam int ERR_W   = $clog2(NUM_SENSORS * NUM_SENSORS) + 1;
    localparam int CNT_W   = $clog2(NUM_SENSORS + 1);
    localparam int SUM_W   = ERR_W + 10;
    localparam int SPD_X   = SPEED_W + 2;
    localparam int RUN_MAX = (LOST_SAMPLES > STOP_SAMPLES) ? LOST_SAMPLES : STOP_SAMPLES;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int STAGES  = 2;

    logic [STAGES:0]         vld_pipe;
    logic [ERR_W-1:0]        err1_raw;
    logic signed [ERR_W-1:0] err1;
    logic [CNT_W-1:0]        cnt1;

    ctrl_state_t             state, state_nx;
    logic [RUN_W-1:0]        empty_run, full_run, empty_nx, full_nx, empty_inc, full_inc;
    logic signed [ERR_W-1:0] prev_err;
    logic                    last_neg;

    logic signed [SUM_W-1:0] err_x, prev_x, kp_x, kd_x, sum_c, corr_c, corr_r;
    logic signed [SPD_X-1:0] left_x, right_x;
    logic [SPEED_W-1:0]      left_sat, right_sat;

    line_position_estimator #(
        .NUM_SENSORS(NUM_SENSORS),
        .ERR_W      (ERR_W),
        .CNT_W      (CNT_W)
    ) u_pos (
        .clk    (clk),
        .reset_n(reset_n),
        .sample (sample),
        .err    (err1_raw),
        .cnt    (cnt1)
    );

    assign err1 = $signed(err1_raw);

    // Dropping enable discards everything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:0], sample_valid};
    end

    always_comb begin
        state_nx  = state;
        empty_nx  = empty_run;
        full_nx   = full_run;
        empty_inc = (cnt1 == '0) ? empty_run + 1'b1 : '0;
        full_inc  = (cnt1 == CNT_W'(NUM_SENSORS)) ? full_run + 1'b1 : '0;
        if (!enable) begin
            state_nx = ST_IDLE;
            empty_nx = '0;
            full_nx  = '0;
        end else if (vld_pipe[1]) begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_TRACK;
                    empty_nx = empty_inc;
                    full_nx  = full_inc;
                end
                ST_TRACK: begin
                    empty_nx = empty_inc;
                    full_nx  = full_inc;
                    if (empty_inc >= RUN_W'(LOST_SAMPLES)) begin
                        state_nx = ST_SEARCH;
                        empty_nx = '0;
                        full_nx  = '0;
                    end else if (full_inc >= RUN_W'(STOP_SAMPLES)) begin
                        state_nx = ST_STOP;
                        empty_nx = '0;
                        full_nx  = '0;
                    end
                end
                ST_SEARCH: begin
                    if (cnt1 != '0 && cnt1 != CNT_W'(NUM_SENSORS))
                        state_nx = ST_TRACK;
                end
                default: ;
            endcase
        end
    end

    // A sample that enters TRACK sees a zero previous error.
    always_comb begin
        err_x  = SUM_W'(err1);
        prev_x = (state == ST_TRACK) ? SUM_W'(prev_err) : '0;
        kp_x   = SUM_W'(kp);
        kd_x   = SUM_W'(kd);
        sum_c  = kp_x * err_x + kd_x * (err_x - prev_x);
        corr_c = sum_c >>> KSHIFT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            empty_run <= '0;
            full_run  <= '0;
            prev_err  <= '0;
            last_neg  <= 1'b0;
            corr_r    <= '0;
        end else begin
            empty_run <= empty_nx;
            full_run  <= full_nx;
            if (!enable) begin
                prev_err <= '0;
            end else if (vld_pipe[1]) begin
                prev_err <= (state_nx == ST_TRACK) ? err1 : '0;
                corr_r   <= corr_c;
                if (err1 != '0)
                    last_neg <= err1[ERR_W-1];
            end
        end
    end

    always_comb begin
        left_x    = $signed({2'b00, base_speed}) + SPD_X'(corr_r);
        right_x   = $signed({2'b00, base_speed}) - SPD_X'(corr_r);
        left_sat  = SPEED_W'(sat_speed(SAT_W'(left_x), SPEED_W));
        right_sat = SPEED_W'(sat_speed(SAT_W'(right_x), SPEED_W));
    end

    // Output stage follows the state reached by the sample leaving stage 2.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            left_speed   <= '0;
            right_speed  <= '0;
            left_dir     <= 1'b1;
            right_dir    <= 1'b1;
            update_valid <= 1'b0;
            ctrl_state   <= ST_IDLE;
            line_lost    <= 1'b0;
        end else begin
            update_valid <= vld_pipe[2] && (state == ST_TRACK || state == ST_SEARCH);
            ctrl_state   <= state;
            line_lost    <= (state == ST_SEARCH);
            if (vld_pipe[2]) begin
                case (state)
                    ST_TRACK: begin
                        left_speed  <= left_sat;
                        right_speed <= right_sat;
                        left_dir    <= 1'b1;
                        right_dir   <= 1'b1;
                    end
                    ST_SEARCH: begin
                        left_speed  <= SPEED_W'(SEARCH_SPEED);
                        right_speed <= SPEED_W'(SEARCH_SPEED);
                        left_dir    <= ~last_neg;
                        right_dir   <= last_neg;
                    end
                    default: begin
                        left_speed  <= '0;
                        right_speed <= '0;
                        left_dir    <= 1'b1;
                        right_dir   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_steering_controller.sv
// Bench for line_steering_controller: directed vector tables, flush sequences,
// and randomized bursts checked against a sample-level reference model.
module tb_line_steering_controller;

    localparam int N     = 8;
    localparam int SW    = 21;
    localparam int LOST  = 3;
    localparam int STOPN = 2;
    localparam int SRCH  = 500;
    localparam int SMAX  = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset_n, enable, sample_valid;
    logic [N-1:0]  sample;
    logic [SW-1:0] base_speed;
    logic [7:0]    kp, kd;
    logic [SW-1:0] left_speed, right_speed;
    logic          left_dir, right_dir, update_valid, line_lost;
    logic [1:0]    ctrl_state;

    line_steering_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .sample_valid(sample_valid),
        .sample      (sample),
        .base_speed  (base_speed),
        .kp          (kp),
        .kd          (kd),
        .left_speed  (left_speed),
        .right_speed (right_speed),
        .left_dir    (left_dir),
        .right_dir   (right_dir),
        .update_valid(update_valid),
        .ctrl_state  (ctrl_state),
        .line_lost   (line_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] smp;
        int         kp, kd, base, l, r;
        bit         ld, rd;
        int         st;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] smp;
    } pend_t;

    localparam logic [47:0] IDLE_OBS = {1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 21'd0, 21'd0};

    int    n_checks = 0, n_pass = 0, cyc = 0;
    pend_t q[$];
    int    m_state, m_prev, m_empty, m_full;
    bit    m_neg;
    int    x_l, x_r, x_st;
    bit    x_ld, x_rd, x_uv;
    vec_t  tbl_a[11];
    vec_t  tbl_b[4];

    function automatic logic [47:0] obs();
        return {update_valid, ctrl_state, line_lost, left_dir, right_dir, left_speed, right_speed};
    endfunction

    function automatic logic [47:0] model_obs();
        return {x_uv, 2'(x_st), (x_st == 2), x_ld, x_rd, 21'(x_l), 21'(x_r)};
    endfunction

    function automatic logic [47:0] vec_obs(input vec_t v);
        return {(v.st == 1 || v.st == 2), 2'(v.st), (v.st == 2), v.ld, v.rd, 21'(v.l), 21'(v.r)};
    endfunction

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > SMAX) return SMAX;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_idle(input bit clr_sign);
        m_state = 0; m_prev = 0; m_empty = 0; m_full = 0;
        if (clr_sign) m_neg = 0;
        q.delete();
        x_l = 0; x_r = 0; x_ld = 1; x_rd = 1; x_uv = 0; x_st = 0;
    endtask

    // One sample's effect on state and outputs, from the behavioural rules.
    task automatic model_step(input logic [7:0] s);
        int e, c, prev, corr;
        e = 0; c = 0;
        for (int i = 0; i < N; i++)
            if (s[i]) begin e += 2 * i - (N - 1); c++; end
        prev = (m_state == 1) ? m_prev : 0;
        corr = int'(kp) * e + int'(kd) * (e - prev);
        if (e != 0) m_neg = (e < 0);
        case (m_state)
            0: begin
                m_state = 1;
                m_empty = (c == 0) ? 1 : 0;
                m_full  = (c == N) ? 1 : 0;
            end
            1: begin
                m_empty = (c == 0) ? m_empty + 1 : 0;
                m_full  = (c == N) ? m_full + 1 : 0;
                if (m_empty >= LOST) begin m_state = 2; m_empty = 0; m_full = 0; end
                else if (m_full >= STOPN) begin m_state = 3; m_empty = 0; m_full = 0; end
            end
            2: if (c > 0 && c < N) m_state = 1;
            default: ;
        endcase
        m_prev = (m_state == 1) ? e : 0;
        x_st = m_state;
        case (m_state)
            1: begin
                x_l = sat(int'(base_speed) + corr); x_r = sat(int'(base_speed) - corr);
                x_ld = 1; x_rd = 1; x_uv = 1;
            end
            2: begin
                x_l = SRCH; x_r = SRCH; x_ld = !m_neg; x_rd = m_neg; x_uv = 1;
            end
            default: begin
                x_l = 0; x_r = 0; x_ld = 1; x_rd = 1; x_uv = 0;
            end
        endcase
    endtask

    task automatic tick();
        pend_t p;
        @(posedge clk);
        cyc++;
        if (!reset_n) model_idle(1);
        else if (!enable) model_idle(0);
        else begin
            x_uv = 0;
            if (sample_valid) q.push_back('{cyc + 3, sample});
            if (q.size() > 0 && q[0].due == cyc) begin
                p = q.pop_front();
                model_step(p.smp);
            end
        end
        #1;
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        kp = 8'(v.kp); kd = 8'(v.kd); base_speed = SW'(v.base);
        sample = v.smp; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        check({name, "_uv_early"}, update_valid, 0);
        tick();
        check(name, obs(), vec_obs(v));
    endtask

    initial begin
        tbl_a[0]  = '{8'h18, 4, 0, 1000, 1000, 1000, 1, 1, 1};
        tbl_a[1]  = '{8'hC0, 4, 2, 1000, 1072,  928, 1, 1, 1};
        tbl_a[2]  = '{8'h03, 4, 2, 1000,  904, 1096, 1, 1, 1};
        tbl_a[3]  = '{8'hC0, 4, 0,   10,   58,    0, 1, 1, 1};
        tbl_a[4]  = '{8'h00, 4, 0, 1000, 1000, 1000, 1, 1, 1};
        tbl_a[5]  = '{8'h00, 4, 0, 1000, 1000, 1000, 1, 1, 1};
        tbl_a[6]  = '{8'h00, 4, 0, 1000,  500,  500, 1, 0, 2};
        tbl_a[7]  = '{8'h01, 4, 0, 1000,  972, 1028, 1, 1, 1};
        tbl_a[8]  = '{8'hFF, 4, 0, 1000, 1000, 1000, 1, 1, 1};
        tbl_a[9]  = '{8'hFF, 4, 0, 1000,    0,    0, 1, 1, 3};
        tbl_a[10] = '{8'h18, 4, 0, 1000,    0,    0, 1, 1, 3};
        tbl_b[0]  = '{8'h03, 4, 0, 1000,  952, 1048, 1, 1, 1};
        tbl_b[1]  = '{8'h00, 4, 0, 1000, 1000, 1000, 1, 1, 1};
        tbl_b[2]  = '{8'h00, 4, 0, 1000, 1000, 1000, 1, 1, 1};
        tbl_b[3]  = '{8'h00, 4, 0, 1000,  500,  500, 0, 1, 2};

        reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0;
        base_speed = SW'(1000); kp = 8'd4; kd = 8'd0;
        model_idle(1);
        repeat (3) tick();
        check("reset", obs(), IDLE_OBS);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        check("idle_after_reset", obs(), IDLE_OBS);

        for (int i = 0; i < 11; i++) apply_vec($sformatf("vec_a%0d", i), tbl_a[i]);

        // STOP releases to IDLE once enable drops.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check("stop_to_idle", obs(), IDLE_OBS);

        // enable dropped one cycle after a strobe: the in-flight sample vanishes.
        apply_vec("pre_drop", '{8'hC0, 4, 0, 1000, 1048, 952, 1, 1, 1});
        sample = 8'h03; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0; enable = 1'b0;
        tick();
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("drop_flush%0d", k), obs(), IDLE_OBS);
        end

        // Same again with a reset pulse instead of enable.
        apply_vec("pre_rst", '{8'hC0, 4, 0, 1000, 1048, 952, 1, 1, 1});
        sample = 8'h03; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rst_flush%0d", k), obs(), IDLE_OBS);
        end

        // Lost line after a left-of-centre error spins the other way.
        for (int i = 0; i < 4; i++) apply_vec($sformatf("vec_b%0d", i), tbl_b[i]);

        // Randomized back-to-back bursts against the reference model.
        for (int b = 0; b < 12; b++) begin
            case (b % 3)
                0:       base_speed = SW'($urandom_range(0, 200));
                1:       base_speed = SW'($urandom_range(500, 3000));
                default: base_speed = SW'(SMAX - int'($urandom_range(0, 300)));
            endcase
            kp = 8'($urandom_range(0, 255));
            kd = 8'($urandom_range(0, 255));
            enable = 1'b0; sample_valid = 1'b0;
            tick();
            enable = 1'b1;
            for (int k = 0; k < 40; k++) begin
                sample_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0:       sample = 8'h00;
                    1:       sample = 8'hFF;
                    default: sample = 8'($urandom);
                endcase
                tick();
                check($sformatf("rand_b%0d_c%0d", b, k), obs(), model_obs());
            end
            sample_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                check($sformatf("rand_b%0d_drain%0d", b, k), obs(), model_obs());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
